// File: rtl/ir_pipe_buffer_if.sv
// Fetch/pipe bundle for ir_pipe_buffer: fetch handshake, pipe controls and the
// execute/writeback instruction and PC outputs.
interface ir_pipe_buffer_if;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        br_taken;
    logic        mem_stall;
    logic [31:0] IRbuffer1_out;
    logic [31:0] pc1_out;
    logic        valid1;
    logic [31:0] IRbuffer2_out;
    logic [31:0] pc2_out;
    logic        valid2;
    logic        flushing;

    modport master (
        output if_valid, if_inst, if_pc, br_taken, mem_stall,
        input  if_ready, IRbuffer1_out, pc1_out, valid1,
               IRbuffer2_out, pc2_out, valid2, flushing
    );

    modport slave (
        input  if_valid, if_inst, if_pc, br_taken, mem_stall,
        output if_ready, IRbuffer1_out, pc1_out, valid1,
               IRbuffer2_out, pc2_out, valid2, flushing
    );
endinterface

// File: rtl/ir_pipe_buffer.sv
// Execute/writeback IR+PC pipe stage with stall freeze and post-branch flush FSM.
// Optional PIPE_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module ir_pipe_buffer #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    ir_pipe_buffer_if.slave    bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);
    typedef enum logic [0:0] {RUN, FLUSH} state_t;

    state_t      state;
    logic [2:0]  fcnt;
    logic [31:0] ir1, pc1, ir2, pc2;
    logic        v1, v2;
    logic        adv;
    logic        redirect;

    assign adv      = !bus.mem_stall;
    // A branch is only honoured from a real instruction while the pipe moves.
    assign redirect = adv && (state == RUN) && bus.br_taken && v1;

    assign bus.if_ready      = adv;
    assign bus.IRbuffer1_out = ir1;
    assign bus.pc1_out       = pc1;
    assign bus.valid1        = v1;
    assign bus.IRbuffer2_out = ir2;
    assign bus.pc2_out       = pc2;
    assign bus.valid2        = v2;
    assign bus.flushing      = (state == FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
            ir1   <= NOP_INST;
            pc1   <= '0;
            v1    <= 1'b0;
            ir2   <= NOP_INST;
            pc2   <= '0;
            v2    <= 1'b0;
        end else if (adv) begin
            ir2 <= ir1;
            pc2 <= pc1;
            v2  <= v1;
            case (state)
                RUN: begin
                    if (redirect) begin
                        ir1 <= NOP_INST;
                        pc1 <= '0;
                        v1  <= 1'b0;
                        if (FLUSH_CYCLES != 0) begin
                            state <= FLUSH;
                            fcnt  <= 3'(FLUSH_CYCLES);
                        end
                    end else if (bus.if_valid) begin
                        ir1 <= bus.if_inst;
                        pc1 <= bus.if_pc;
                        v1  <= 1'b1;
                    end else begin
                        ir1 <= NOP_INST;
                        pc1 <= '0;
                        v1  <= 1'b0;
                    end
                end
                FLUSH: begin
                    ir1  <= NOP_INST;
                    pc1  <= '0;
                    v1   <= 1'b0;
                    fcnt <= fcnt - 3'd1;
                    if (fcnt == 3'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.mem_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ir_pipe_buffer.sv
// Self-checking bench for ir_pipe_buffer: per-cycle vector table, stage-2 scoreboard,
// and hand sequences for reset, FLUSH_CYCLES=0 and reset mid-flush.
module tb_ir_pipe_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ir_pipe_buffer_if ifc1 ();
    ir_pipe_buffer_if ifc0 ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] s1, f1, s0, f0;
`endif

    ir_pipe_buffer #(.FLUSH_CYCLES(1), .NOP_INST(NOP)) dut1 (
        .clk(clk), .rst(rst), .bus(ifc1)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(s1), .flush_cnt(f1)
`endif
    );

    ir_pipe_buffer #(.FLUSH_CYCLES(0), .NOP_INST(NOP)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(s0), .flush_cnt(f0)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        st, iv;
        logic [31:0] inst, pc;
        logic        br, acc;
        logic [31:0] e_ir1, e_pc1;
        logic        e_v1, e_v2, e_fl;
    } vec_t;

    function automatic vec_t mk(logic st, logic iv, logic [31:0] inst, logic [31:0] pc,
                                logic br, logic acc, logic [31:0] e_ir1, logic [31:0] e_pc1,
                                logic e_v1, logic e_v2, logic e_fl);
        vec_t v;
        v.st = st; v.iv = iv; v.inst = inst; v.pc = pc; v.br = br; v.acc = acc;
        v.e_ir1 = e_ir1; v.e_pc1 = e_pc1; v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_fl = e_fl;
        return v;
    endfunction

    // Scoreboard of real instructions expected to reach the writeback stage, in order.
    typedef struct { logic [31:0] inst, pc; } sb_t;
    sb_t sbq[$];
    logic adv_q = 1'b0;

    always @(posedge clk) adv_q <= !ifc1.mem_stall;

    always @(negedge clk) begin
        if (adv_q && ifc1.valid2) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_valid2_pc", ifc1.pc2_out, 32'hFFFF_FFFF);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_ir2", ifc1.IRbuffer2_out, e.inst);
                chk("sb_pc2", ifc1.pc2_out, e.pc);
            end
        end
    end

    task automatic drive1(input logic st, input logic iv, input logic [31:0] inst,
                          input logic [31:0] pc, input logic br);
        ifc1.mem_stall = st; ifc1.if_valid = iv; ifc1.if_inst = inst;
        ifc1.if_pc = pc; ifc1.br_taken = br;
    endtask

    task automatic drive0(input logic iv, input logic [31:0] inst,
                          input logic [31:0] pc, input logic br);
        ifc0.mem_stall = 1'b0; ifc0.if_valid = iv; ifc0.if_inst = inst;
        ifc0.if_pc = pc; ifc0.br_taken = br;
    endtask

    vec_t tv[21];

    initial begin
        logic [31:0] I1, I2, I3, I4, T1, T2, T3, T4, T5, W1, W2, W3;
        I1 = 32'h0050_0093; I2 = 32'h0010_8133; I3 = 32'h0020_81B3; I4 = 32'h0031_0233;
        T1 = 32'h0040_0293; T2 = 32'h0050_0313; T3 = 32'h0060_0393; T4 = 32'h0070_0413;
        T5 = 32'h0080_0493; W1 = 32'hBAD0_0001; W2 = 32'hBAD0_0002; W3 = 32'hBAD0_0003;

        //         st iv inst pc      br acc  e_ir1 e_pc1 v1 v2 fl
        tv[0]  = mk(0, 1, I1, 32'd0,  0, 1,   I1, 32'd0,  1, 0, 0);
        tv[1]  = mk(0, 1, I2, 32'd4,  0, 1,   I2, 32'd4,  1, 1, 0);
        tv[2]  = mk(1, 1, I3, 32'd8,  0, 0,   I2, 32'd4,  1, 1, 0);
        tv[3]  = mk(1, 1, I3, 32'd8,  0, 0,   I2, 32'd4,  1, 1, 0);
        tv[4]  = mk(1, 1, I3, 32'd8,  0, 0,   I2, 32'd4,  1, 1, 0);
        tv[5]  = mk(0, 1, I3, 32'd8,  0, 1,   I3, 32'd8,  1, 1, 0);
        tv[6]  = mk(0, 1, I4, 32'd12, 0, 1,   I4, 32'd12, 1, 1, 0);
        tv[7]  = mk(0, 1, W1, 32'd16, 1, 0,   NOP, 32'd0, 0, 1, 1);
        tv[8]  = mk(0, 1, W2, 32'd20, 0, 0,   NOP, 32'd0, 0, 0, 0);
        tv[9]  = mk(0, 1, T1, 32'd64, 0, 1,   T1, 32'd64, 1, 0, 0);
        tv[10] = mk(0, 1, T2, 32'd68, 1, 0,   NOP, 32'd0, 0, 1, 1);
        tv[11] = mk(1, 1, W3, 32'd72, 0, 0,   NOP, 32'd0, 0, 1, 1);
        tv[12] = mk(1, 1, W3, 32'd72, 0, 0,   NOP, 32'd0, 0, 1, 1);
        tv[13] = mk(0, 1, W3, 32'd72, 0, 0,   NOP, 32'd0, 0, 0, 0);
        tv[14] = mk(0, 1, T3, 32'd72, 0, 1,   T3, 32'd72, 1, 0, 0);
        tv[15] = mk(0, 0, W1, 32'd0,  0, 0,   NOP, 32'd0, 0, 1, 0);
        tv[16] = mk(0, 1, T4, 32'd76, 1, 1,   T4, 32'd76, 1, 0, 0);
        tv[17] = mk(1, 1, T5, 32'd80, 1, 0,   T4, 32'd76, 1, 0, 0);
        tv[18] = mk(0, 1, T5, 32'd80, 0, 1,   T5, 32'd80, 1, 1, 0);
        tv[19] = mk(0, 0, W2, 32'd0,  0, 0,   NOP, 32'd0, 0, 1, 0);
        tv[20] = mk(0, 0, W2, 32'd0,  0, 0,   NOP, 32'd0, 0, 0, 0);

        // Reset with a stream already presented; if_ready tracks mem_stall throughout.
        rst = 1'b1;
        drive1(1, 1, W1, 32'h100, 1);
        drive0(0, '0, '0, 0);
        #1 chk("rst_if_ready_stalled", 32'(ifc1.if_ready), 32'd0);
        ifc1.mem_stall = 1'b0;
        #1 chk("rst_if_ready_running", 32'(ifc1.if_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ir1", ifc1.IRbuffer1_out, NOP);
        chk("rst_ir2", ifc1.IRbuffer2_out, NOP);
        chk("rst_pc1", ifc1.pc1_out, 32'd0);
        chk("rst_v1", 32'(ifc1.valid1), 32'd0);
        chk("rst_v2", 32'(ifc1.valid2), 32'd0);
        chk("rst_flushing", 32'(ifc1.flushing), 32'd0);
        drive1(0, 0, '0, '0, 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive1(tv[i].st, tv[i].iv, tv[i].inst, tv[i].pc, tv[i].br);
            if (tv[i].acc) sbq.push_back('{tv[i].inst, tv[i].pc});
            #1 chk($sformatf("v%0d_if_ready", i), 32'(ifc1.if_ready), 32'(!tv[i].st));
            @(posedge clk); #1;
            chk($sformatf("v%0d_ir1", i), ifc1.IRbuffer1_out, tv[i].e_ir1);
            chk($sformatf("v%0d_pc1", i), ifc1.pc1_out, tv[i].e_pc1);
            chk($sformatf("v%0d_v1", i), 32'(ifc1.valid1), 32'(tv[i].e_v1));
            chk($sformatf("v%0d_v2", i), 32'(ifc1.valid2), 32'(tv[i].e_v2));
            chk($sformatf("v%0d_flushing", i), 32'(ifc1.flushing), 32'(tv[i].e_fl));
`ifdef PIPE_PERF_CNT_EN
            if (i == 4) chk("stall_cnt_after_3", s1, 32'd3);
            if (i == 8) chk("flush_cnt_after_1", f1, 32'd1);
`endif
        end
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt_total", s1, 32'd6);
        chk("flush_cnt_total", f1, 32'd2);
`endif
        drive1(0, 0, '0, '0, 0);

        // FLUSH_CYCLES=0: a single bubble and no FLUSH state.
        drive0(1, 32'h00A0_0513, 32'h40, 0);
        @(posedge clk); #1;
        chk("fc0_a_ir1", ifc0.IRbuffer1_out, 32'h00A0_0513);
        drive0(1, W1, 32'h44, 1);
        @(posedge clk); #1;
        chk("fc0_b_ir1", ifc0.IRbuffer1_out, NOP);
        chk("fc0_b_v1", 32'(ifc0.valid1), 32'd0);
        chk("fc0_b_fl", 32'(ifc0.flushing), 32'd0);
        chk("fc0_b_ir2", ifc0.IRbuffer2_out, 32'h00A0_0513);
        drive0(1, 32'h00B0_0593, 32'h80, 0);
        @(posedge clk); #1;
        chk("fc0_c_ir1", ifc0.IRbuffer1_out, 32'h00B0_0593);
        chk("fc0_c_v1", 32'(ifc0.valid1), 32'd1);
        chk("fc0_c_fl", 32'(ifc0.flushing), 32'd0);
        drive0(0, '0, '0, 0);
        @(posedge clk); #1;
        chk("fc0_d_ir2", ifc0.IRbuffer2_out, 32'h00B0_0593);
        chk("fc0_d_v2", 32'(ifc0.valid2), 32'd1);
`ifdef PIPE_PERF_CNT_EN
        chk("fc0_flush_cnt", f0, 32'd1);
`endif

        // Reset while FLUSH is active clears everything at once.
        drive1(0, 1, 32'h0123_4567, 32'h200, 0);
        sbq.push_back('{32'h0123_4567, 32'h200});
        @(posedge clk); #1;
        drive1(0, 1, W2, 32'h204, 1);
        @(posedge clk); #1;
        chk("mf_flushing_set", 32'(ifc1.flushing), 32'd1);
        drive1(0, 1, W3, 32'h208, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mf_rst_flushing", 32'(ifc1.flushing), 32'd0);
        chk("mf_rst_ir1", ifc1.IRbuffer1_out, NOP);
        chk("mf_rst_v1", 32'(ifc1.valid1), 32'd0);
        chk("mf_rst_ir2", ifc1.IRbuffer2_out, NOP);
        chk("mf_rst_v2", 32'(ifc1.valid2), 32'd0);
`ifdef PIPE_PERF_CNT_EN
        chk("mf_rst_stall_cnt", s1, 32'd0);
        chk("mf_rst_flush_cnt", f1, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        drive1(0, 0, '0, '0, 0);
        @(posedge clk); #1;
        chk("mf_after_flushing", 32'(ifc1.flushing), 32'd0);
        chk("sb_leftover", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
